sha_io_ctrl: RTL

Host-side byte interface for the SHA-256 core. It is the other end of the controller's start/hash_ready handshake. It assembles a 512-bit message block from a byte stream and issues a one-cycle start pulse. It then waits for hash_ready, captures the 256-bit digest and streams it back out byte by byte. It sits between the chip I/O pins and the controller/datapath.

---
 rtl/sha_io_pkg.sv | 15 +
 rtl/sha_byte_shreg.sv | 33 +++
 rtl/sha_io_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sha_io_pkg.sv
// Shared types and constants for the SHA-256 host byte interface.
package sha_io_pkg;

  localparam int unsigned ByteW          = 8;
  localparam int unsigned DefMsgBytes    = 64;
  localparam int unsigned DefDigestBytes = 32;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StFire  = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/sha_byte_shreg.sv
// Byte-wide shift register: parallel load, or shift left one byte with a new LSB byte.
module sha_byte_shreg
  import sha_io_pkg::*;
#(
  parameter int unsigned WIDTH = 512
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic [ByteW-1:0] i_byte,
  output logic [WIDTH-1:0] o_value,
  output logic [ByteW-1:0] o_byte
);

  logic [WIDTH-1:0] r_data;

  // Load has priority; the two are never asserted together by the controller.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_val;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-ByteW-1:0], i_byte};
    end
  end

  assign o_value = r_data;
  assign o_byte  = r_data[WIDTH-1 -: ByteW];

endmodule

// File: rtl/sha_io_ctrl.sv
// Host byte interface: assembles a message block, pulses start, waits for hash_ready,
// then streams the captured digest out MSB byte first.
module sha_io_ctrl
  import sha_io_pkg::*;
#(
  parameter int unsigned MSG_BYTES      = DefMsgBytes,
  parameter int unsigned DIGEST_BYTES   = DefDigestBytes,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                data_in,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  output logic [8*MSG_BYTES-1:0]    msg_block,
  output logic                      start,
  input  logic                      hash_ready,
  input  logic [8*DIGEST_BYTES-1:0] digest_in,
  output logic [7:0]                data_out,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic                      busy,
  output logic                      error
);

  localparam int unsigned MsgW = ByteW * MSG_BYTES;
  localparam int unsigned DigW = ByteW * DIGEST_BYTES;
  localparam int unsigned BcW  = $clog2(MSG_BYTES + 1);
  localparam int unsigned DcW  = $clog2(DIGEST_BYTES + 1);

  localparam logic [BcW-1:0] ByteLast  = BcW'(MSG_BYTES - 1);
  localparam logic [DcW-1:0] DrainLast = DcW'(DIGEST_BYTES - 1);
  localparam logic [15:0]    ToLast    = 16'(TIMEOUT_CYCLES - 1);

  state_e         r_state_q, w_state_d;
  logic [BcW-1:0] r_byte_cnt_q, w_byte_cnt_d;
  logic [DcW-1:0] r_drain_cnt_q, w_drain_cnt_d;
  logic [15:0]    r_to_cnt_q, w_to_cnt_d;
  logic           r_err_q, w_err_d;
  logic           r_hr_q;

  logic w_accept;
  logic w_rise;
  logic w_capture;
  logic w_dout_hs;

  assign w_accept  = data_in_valid && (r_state_q == StLoad);
  assign w_rise    = hash_ready && !r_hr_q;
  assign w_capture = w_rise && (r_state_q == StWait);
  assign w_dout_hs = data_out_ready && (r_state_q == StDrain);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q     <= StLoad;
      r_byte_cnt_q  <= '0;
      r_drain_cnt_q <= '0;
      r_to_cnt_q    <= '0;
      r_err_q       <= 1'b0;
      r_hr_q        <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_byte_cnt_q  <= w_byte_cnt_d;
      r_drain_cnt_q <= w_drain_cnt_d;
      r_to_cnt_q    <= w_to_cnt_d;
      r_err_q       <= w_err_d;
      r_hr_q        <= hash_ready;
    end
  end

  always_comb begin
    w_state_d     = r_state_q;
    w_byte_cnt_d  = r_byte_cnt_q;
    w_drain_cnt_d = r_drain_cnt_q;
    w_to_cnt_d    = r_to_cnt_q;
    w_err_d       = r_err_q;

    unique case (r_state_q)
      StLoad: begin
        if (w_accept) begin
          w_err_d = 1'b0;
          if (r_byte_cnt_q == ByteLast) begin
            w_byte_cnt_d = '0;
            w_state_d    = StFire;
          end else begin
            w_byte_cnt_d = r_byte_cnt_q + 1'b1;
          end
        end
      end
      StFire: begin
        w_state_d = StWait;
      end
      StWait: begin
        // A completion edge beats a timeout landing on the same cycle.
        if (w_rise) begin
          w_to_cnt_d = '0;
          w_state_d  = StDrain;
        end else if (r_to_cnt_q == ToLast) begin
          w_to_cnt_d = '0;
          w_err_d    = 1'b1;
          w_state_d  = StLoad;
        end else begin
          w_to_cnt_d = r_to_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (w_dout_hs) begin
          if (r_drain_cnt_q == DrainLast) begin
            w_drain_cnt_d = '0;
            w_state_d     = StLoad;
          end else begin
            w_drain_cnt_d = r_drain_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StLoad;
      end
    endcase
  end

  sha_byte_shreg #(
    .WIDTH (MsgW)
  ) u_msg_shreg (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_shift    (w_accept),
    .i_byte     (data_in),
    .o_value    (msg_block),
    .o_byte     ()
  );

  sha_byte_shreg #(
    .WIDTH (DigW)
  ) u_dig_shreg (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_capture),
    .i_load_val (digest_in),
    .i_shift    (w_dout_hs),
    .i_byte     (8'h00),
    .o_value    (),
    .o_byte     (data_out)
  );

  assign data_in_ready  = (r_state_q == StLoad);
  assign start          = (r_state_q == StFire);
  assign data_out_valid = (r_state_q == StDrain);
  assign busy           = (r_state_q != StLoad);
  assign error          = r_err_q;

endmodule
